// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_ctrl
// Brief    : Multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb).
//            Optional macro HALT_ON_ILLEGAL_EN: illegal opcode halts the core.
// Revision : 1.0
// ============================================================================
module rv_mc_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_data,
    input  logic        br_taken,
    input  logic        if_ack,
    input  logic        dm_ack,
    output logic        if_req,
    output logic        dm_req,
    output logic        dm_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal_inst,
    output logic        bus_err,
    output logic        halted
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef HALT_ON_ILLEGAL_EN
        , S_HALT = 3'd5
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic [2:0]       imm_sel_r;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_opimm, is_op, is_lui, is_auipc;
    logic       is_jal, is_jalr, is_branch, legal;
    logic       timeout_hit;
    logic [2:0] imm_dec;
    logic       unused_inst;

    assign opcode      = inst_data[6:0];
    assign funct3      = inst_data[14:12];
    assign unused_inst = ^{inst_data[31:15], inst_data[11:7]};

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign legal     = is_load | is_store | is_opimm | is_op | is_lui |
                       is_auipc | is_jal | is_jalr | is_branch;

    assign timeout_hit = (cnt == TIMEOUT_LAST);
    assign imm_sel     = imm_sel_r;

    always_comb begin
        imm_dec = 3'b000;
        if (is_load && (funct3 == 3'b100 || funct3 == 3'b101)) imm_dec = 3'b101;
        else if (is_store)                                     imm_dec = 3'b001;
        else if (is_lui || is_auipc)                           imm_dec = 3'b010;
        else if (is_jal)                                       imm_dec = 3'b011;
        else if (is_branch)                                    imm_dec = 3'b100;
    end

    // Sequencing; idle masks if_req for the post-reset cycle and after a fetch timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            cnt       <= '0;
            idle      <= 1'b1;
            imm_sel_r <= 3'b000;
        end else begin
            case (state)
                S_FETCH: begin
                    if (idle) begin
                        idle <= 1'b0;
                        cnt  <= '0;
                    end else if (if_ack) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        idle <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        imm_sel_r <= imm_dec;
                        state     <= S_EXEC;
                    end else begin
`ifdef HALT_ON_ILLEGAL_EN
                        state <= S_HALT;
`else
                        state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    cnt <= '0;
                    if (!legal || is_branch || is_jal || is_jalr) state <= S_FETCH;
                    else if (is_load || is_store)                 state <= S_MEM;
                    else                                          state <= S_WB;
                end
                S_MEM: begin
                    if (dm_ack) begin
                        cnt   <= '0;
                        state <= is_store ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WB: begin
                    cnt   <= '0;
                    state <= S_FETCH;
                end
`ifdef HALT_ON_ILLEGAL_EN
                S_HALT: state <= S_HALT;
`endif
                default: begin
                    cnt   <= '0;
                    idle  <= 1'b1;
                    state <= S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        if_req       = 1'b0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        illegal_inst = 1'b0;
        bus_err      = 1'b0;
        halted       = 1'b0;
        case (state)
            S_FETCH: begin
                if (!idle) begin
                    if_req = 1'b1;
                    if (if_ack)           ir_we   = 1'b1;
                    else if (timeout_hit) bus_err = 1'b1;
                end
            end
            S_DECODE: illegal_inst = !legal;
            S_EXEC: begin
                if (!legal) begin
                    pc_we = 1'b1;
                end else begin
                    alu_src_b = !(is_op || is_branch);
                    if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'b01 : 2'b00;
                    end else if (is_jal || is_jalr) begin
                        pc_we  = 1'b1;
                        pc_sel = is_jal ? 2'b01 : 2'b10;
                        reg_we = 1'b1;
                        wb_sel = 2'b10;
                    end
                end
            end
            S_MEM: begin
                dm_req    = 1'b1;
                dm_we     = is_store;
                alu_src_b = 1'b1;
                if (dm_ack) pc_we = is_store;
                else        bus_err = timeout_hit;
            end
            S_WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = !is_op;
                if (is_load)     wb_sel = 2'b01;
                else if (is_lui) wb_sel = 2'b11;
            end
`ifdef HALT_ON_ILLEGAL_EN
            S_HALT: halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It drives the instruction-fetch and data-memory req/ack handshakes and the IR/PC/register-file write enables. It decodes the current instruction word to produce the immediate-format select for the immediate generator, the ALU operand-B select and the writeback select. Each instruction runs through FETCH, DECODE, EXEC, then MEM and/or WB where needed.

Parameters:
ACK_TIMEOUT, 16, cycles in FETCH or MEM without ack before the access is aborted (legal range 2..2**CNT_W-1)
CNT_W, 5, width of the wait-cycle counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
inst_data  in  32  instruction register contents; stable from the cycle after ir_we
br_taken  in  1  branch comparison result from ALU; valid in EXEC
if_ack  in  1  instruction memory ack
dm_ack  in  1  data memory ack
if_req  out  1  instruction fetch request
dm_req  out  1  data memory request
dm_we  out  1  data memory write (store)
ir_we  out  1  latch fetched word into IR
pc_we  out  1  update PC
pc_sel  out  2  PC source: 00 pc+4, 01 pc+imm (branch/JAL), 10 rs1+imm (JALR)
imm_sel  out  3  immediate format: 000 I, 001 S, 010 U, 011 J, 100 B, 101 zero-extended I
alu_src_b  out  1  0 rs2, 1 immediate
reg_we  out  1  register file write
wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 pc+4, 11 immediate
illegal_inst  out  1  one-cycle pulse on an undecodable opcode
bus_err  out  1  one-cycle pulse on an ack timeout
halted  out  1  core halted (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): state=FETCH, counter=0, imm_sel=000. All other outputs 0. The first if_req rises in the first clock after rst_n deasserts. Reset mid-access drops req immediately with no handshake completion; a later ack is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT (HALT exists only with macro).
- Outputs are decoded from registered state plus inputs; ir_we, pc_we, reg_we and dm_req are never asserted in the reset cycle.
- Counter: cleared on entry to FETCH or MEM; increments each cycle req is high without ack.
- FETCH: if_req=1.
  - if_ack=1 -> ir_we=1 in that cycle; next state DECODE.
  - Counter reaching ACK_TIMEOUT-1 without ack -> bus_err=1, if_req drops for one cycle, re-enter FETCH with PC unchanged.
  - An ack arriving when req=0 is ignored.
- DECODE: decode opcode inst_data[6:0] and register imm_sel, held until the next DECODE.
  - LOAD -> 000, or 101 when funct3 is 100/101 (LBU/LHU).
  - JALR and OP-IMM -> 000.
  - STORE -> 001; LUI/AUIPC -> 010; JAL -> 011; BRANCH -> 100.
  - Any other opcode -> illegal_inst=1 for one cycle, then pc_we=1, pc_sel=00, next FETCH (treated as NOP).
  - Legal opcode -> next EXEC.
- EXEC: alu_src_b=1 for every opcode except OP and BRANCH.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 01 : 00; next FETCH.
  - JAL/JALR: pc_we=1, pc_sel=01/10, reg_we=1, wb_sel=10; next FETCH.
  - LOAD/STORE -> MEM. OP/OP-IMM/LUI/AUIPC -> WB.
- MEM: dm_req=1; dm_we=1 only for STORE; held until dm_ack.
  - Store acked -> pc_we=1, pc_sel=00, next FETCH.
  - Load acked -> WB.
  - Timeout -> bus_err pulse, next FETCH with PC unchanged (instruction replayed).
- WB: reg_we=1, pc_we=1, pc_sel=00; next FETCH.
  - wb_sel: 01 for LOAD, 11 for LUI, 00 otherwise (AUIPC uses ALU pc+imm).
- Latency with zero-wait ack: branch 3 cycles, ALU/JAL 4/3, store 4, load 5.
- Simultaneous events: ack in the same cycle the counter reaches its limit -> ack wins, no bus_err.

Optional Feature:
Macro HALT_ON_ILLEGAL_EN.
- Defined: an illegal opcode in DECODE pulses illegal_inst, then enters HALT. In HALT, halted=1, every req/we output is 0 and inputs are ignored. Only rst_n exits HALT.
- Undefined: HALT state is absent, halted is tied 0, and an illegal opcode is treated as a NOP as described above.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0, imm_sel=000. Release -> if_req=1 in the next cycle.
- 0x00500093 (addi) with immediate ack -> imm_sel=000, alu_src_b=1. In WB: reg_we=1, wb_sel=00, pc_sel=00. Exactly 4 cycles per instruction.
- 0x00004103 (lbu), dm_ack delayed 2 cycles -> imm_sel=101, dm_req held 3 cycles with dm_we=0, then WB with wb_sel=01. 0x00102423 (sw) -> imm_sel=001, dm_we=1, no reg_we.
- 0x00000463 (beq) with br_taken=1 then 0 -> imm_sel=100, pc_sel=01 then 00. 0x008000ef (jal) -> imm_sel=011, wb_sel=10, reg_we=1 in EXEC.
- if_ack never asserted -> bus_err pulses at cycle 16 of FETCH, pc_we stays 0, if_req re-raises after 1 idle cycle. Ack in the 16th cycle -> no bus_err.
- inst_data=0x0000007f -> illegal_inst pulse. Macro undefined: pc_we with pc_sel=00, then FETCH. Macro defined: halted=1 and if_req stays 0 until rst_n toggles.
